sequence_generator: RTL and testbench

Serial pattern transmitter. It is the transmit-side counterpart of the team's serial sequence detector (pattern 10110101, one bit per clock).
- Latches a PAT_W-bit pattern and shifts it out MSB-first, one bit per clk.
- Repeats the pattern a programmable number of times, with programmable idle gaps between repetitions.
- Provides a start/busy/done handshake for the controlling logic and for detector loopback benches.

---
 rtl/sequence_generator_pkg.sv | 13 +
 rtl/sequence_generator_if.sv | 26 ++
 rtl/sequence_generator_shift.sv | 27 ++
 rtl/sequence_generator.sv | 130 +++++++++++++
 tb/tb_sequence_generator.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sequence_generator_pkg.sv
// rtl/sequence_generator_pkg.sv - shared state encoding and default pattern
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Also the pattern the receive-side detector looks for.
  localparam logic [7:0] SEQ_PAT_DEFAULT = 8'b10110101;

endpackage

// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - control and serial output bundle of the sequence generator
interface sequence_generator_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) ();
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, reps, gap,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, reps, gap,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/sequence_generator_shift.sv
// rtl/sequence_generator_shift.sv - loadable MSB-first shift register, zero-filling
module seq_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] q;

  // Zero fill means the register drains to all-zero after the last bit,
  // so msb doubles as a registered x that is 0 whenever nothing is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];
endmodule

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - repeating serial pattern transmitter with start/busy/done handshake
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = SEQ_PAT_DEFAULT,
  parameter int               CNT_W       = 4,
  parameter int               GAP_W       = 4
) (
  input logic                clk,
  input logic                rst,
  sequence_generator_if.slave bus
);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic [GAP_W-1:0] gap_q, gap_cnt, gap_n;
  logic [PAT_W-1:0] pat_q, sr_din;
  logic             sr_load, sr_shift, latch, done_n;
  logic             x_valid_q, busy_q, done_q;
  logic             sr_msb;

  seq_shift_reg #(.W(PAT_W)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      gap_q     <= '0;
      pat_q     <= PAT_DEFAULT;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      rep_cnt   <= rep_n;
      gap_cnt   <= gap_n;
      if (latch) begin
        pat_q <= bus.pattern;
        gap_q <= bus.gap;
      end
      x_valid_q <= (state_n == SEND);
      busy_q    <= (state_n != IDLE);
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    rep_n    = rep_cnt;
    gap_n    = gap_cnt;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = pat_q;
    latch    = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.reps != '0) begin
            latch   = 1'b1;
            sr_load = 1'b1;
            sr_din  = bus.pattern;
            idx_n   = IDX_TOP;
            rep_n   = bus.reps;
            state_n = SEND;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          sr_load = 1'b1;
          sr_din  = '0;
          state_n = IDLE;
        end else if (idx == '0) begin
          rep_n = rep_cnt - CNT_W'(1);
          if (rep_cnt == CNT_W'(1)) begin
            sr_shift = 1'b1;
            done_n   = 1'b1;
            state_n  = IDLE;
          end else if (gap_q == '0) begin
            // Back-to-back repetition: reload so the MSB follows bit 0 directly.
            sr_load = 1'b1;
            idx_n   = IDX_TOP;
          end else begin
            sr_shift = 1'b1;
            gap_n    = gap_q - GAP_W'(1);
            state_n  = GAP;
          end
        end else begin
          sr_shift = 1'b1;
          idx_n    = idx - IDX_W'(1);
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (gap_cnt == '0) begin
          sr_load = 1'b1;
          idx_n   = IDX_TOP;
          state_n = SEND;
        end else begin
          gap_n = gap_cnt - GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.x       = sr_msb;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - directed self-checking bench for sequence_generator
module tb_sequence_generator;
  import sequence_generator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  sequence_generator_if #(.PAT_W(8), .CNT_W(4), .GAP_W(4)) bus ();

  sequence_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs();
    return {bus.busy, bus.done, bus.x_valid, bus.x};
  endfunction

  // Expected {busy,done,x_valid,x} for cycle c after the accepting edge.
  function automatic logic [3:0] expect_at(logic [7:0] pat, int reps, int gap, int c);
    int total;
    int off;
    total = (reps == 0) ? 0 : reps * 8 + (reps - 1) * gap;
    if (c <= total) begin
      off = (c - 1) % (8 + gap);
      if (off < 8) return {3'b101, pat[7 - off]};
      return 4'b1000;
    end
    if (c == total + 1) return 4'b0100;
    return 4'b0000;
  endfunction

  task automatic run_expect(input string tag, input logic [7:0] pat, input int reps,
                            input int gap, input bit noise, input bit abort_with_start);
    int total;
    total = (reps == 0) ? 0 : reps * 8 + (reps - 1) * gap;
    bus.pattern = pat;
    bus.reps    = 4'(reps);
    bus.gap     = 4'(gap);
    bus.start   = 1'b1;
    bus.abort   = abort_with_start;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      check($sformatf("%s c%0d", tag, c), 32'(obs()), 32'(expect_at(pat, reps, gap, c)));
      if (noise && c <= total) begin
        bus.start   = 1'b1;
        bus.pattern = 8'($urandom);
        bus.reps    = 4'($urandom_range(1, 15));
        bus.gap     = 4'($urandom_range(0, 15));
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] win;
    logic [7:0] cand;
    int         flags;
    int         misplaced;
    int         done_seen;
    logic [7:0] p;

    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    bus.gap     = '0;
    tick();
    tick();
    check("reset outputs", 32'(obs()), 32'h0);
    rst = 1'b0;
    tick();
    check("idle after reset", 32'(obs()), 32'h0);

    run_expect("single", 8'b10110101, 1, 0, 1'b0, 1'b0);
    run_expect("rep3gap2", 8'hA5, 3, 2, 1'b0, 1'b0);
    run_expect("rep2gap0", 8'h3C, 2, 0, 1'b0, 1'b0);
    run_expect("reps0", 8'hFF, 0, 0, 1'b0, 1'b0);
    run_expect("start busy", 8'hC9, 2, 1, 1'b1, 1'b0);
    run_expect("start+abort", 8'h81, 1, 0, 1'b0, 1'b1);

    // Abort in the first gap cycle.
    bus.pattern = 8'hA5; bus.reps = 4'd3; bus.gap = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check("gap before abort", 32'(obs()), 32'h8);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort in gap", 32'(obs()), 32'h0);
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (obs() != 4'h0) done_seen++;
      tick();
    end
    check("quiet after abort", 32'(done_seen), 32'h0);

    // Reset while sending bit 3 of repetition 2.
    p = 8'hB5;
    bus.pattern = p; bus.reps = 4'd3; bus.gap = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 14; c++) tick();
    check("rep2 bit3", 32'(obs()), 32'({3'b101, p[3]}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset mid send", 32'(obs()), 32'h0);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (obs() != 4'h0) done_seen++;
      tick();
    end
    check("quiet after reset", 32'(done_seen), 32'h0);
    run_expect("after reset", 8'h5A, 2, 3, 1'b0, 1'b0);

    // Loopback into a bench-side 10110101 detector.
    bus.pattern = SEQ_PAT_DEFAULT; bus.reps = 4'd4; bus.gap = 4'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    win = '0; flags = 0; misplaced = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.x_valid) begin
        cand = {win[6:0], bus.x};
        if (cand == SEQ_PAT_DEFAULT) begin
          flags++;
          if ((c - 1) % 10 != 7) misplaced++;
        end
        win = cand;
      end
      tick();
    end
    check("loopback flags", 32'(flags), 32'd4);
    check("loopback flag position", 32'(misplaced), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
